vif_rr_arbiter: RTL and testbench

//  N-channel valid/ready arbiter for my_if-style streams: merges NUM_CH producer channels
//  (data/valid/ready plus last) onto one registered output channel, round-robin fair.

---
 rtl/vif_pkg.sv | 14 +
 rtl/vif_rr_pick.sv | 34 +++
 rtl/vif_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_vif_rr_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vif_pkg.sv
// Shared types for the valid/ready stream arbiter.
// Arbiter FSM states and the channel-index width helper.
package vif_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic int ch_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vif_rr_pick.sv
// Combinational round-robin picker.
// Scans req upward from ptr with wrap; returns one-hot grant and its index.
module vif_rr_pick
    import vif_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = ch_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   idx_o,
    output logic              any_o
);

    int c;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = int'(ptr_i) + i;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (!any_o && req_i[c]) begin
                any_o    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = CH_W'(c);
            end
        end
    end

endmodule

// File: rtl/vif_rr_arbiter.sv
// N-channel round-robin stream merger with registered output
// and optional packet lock that holds the grant until the last beat.
module vif_rr_arbiter
    import vif_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    localparam int CH_W   = ch_idx_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     lock_en,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [CH_W-1:0]          out_chan,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         beat_cnt
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [CH_W-1:0]   out_chan_q, out_chan_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [NUM_CH-1:0] lock_mask;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   pick_idx;
    logic              pick_any;
    logic              load_en;
    logic              acc;
    logic              acc_last;

    // Grant never looks at the output side; load_en only gates ready.
    assign lock_mask = (state_q == LOCKED) ? (NUM_CH'(1) << lock_ch_q) : '1;
    assign req       = in_valid & lock_mask;

    vif_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .req_i  (req),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign load_en  = !out_valid_q || out_ready;
    assign in_ready = gnt & {NUM_CH{load_en}};
    assign acc      = pick_any && load_en;
    assign acc_last = in_last[pick_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            lock_ch_q   <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_ch_q   <= lock_ch_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_chan_q  <= out_chan_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_ch_d   = lock_ch_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_chan_d  = out_chan_q;
        out_data_d  = out_data_q;

        if (acc) begin
            rr_ptr_d = (pick_idx == LAST_CH) ? '0 : pick_idx + 1'b1;
            if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 1'b1;
        end

        // lock_en is only sampled on the first beat of a packet
        unique case (state_q)
            ARB: begin
                if (acc && lock_en && !acc_last) begin
                    state_d   = LOCKED;
                    lock_ch_d = pick_idx;
                end
            end
            LOCKED: begin
                if (acc && acc_last) state_d = ARB;
            end
            default: state_d = ARB;
        endcase

        if (load_en) begin
            out_valid_d = acc;
            if (acc) begin
                out_data_d = in_data[int'(pick_idx)*DATA_W +: DATA_W];
                out_last_d = acc_last;
                out_chan_d = pick_idx;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_chan  = out_chan_q;
    assign out_data  = out_data_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_vif_rr_arbiter.sv
// Bench for vif_rr_arbiter: directed table, stall and reset sequences,
// then random traffic against a behavioural round-robin model.
module tb_vif_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  d [4];
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_last, in_ready, in_ready4;
    logic        lock_en, out_ready;
    logic [7:0]  out_data, out_data4;
    logic        out_last, out_last4, out_valid, out_valid4;
    logic [1:0]  out_chan, out_chan4;
    logic [15:0] beat_cnt;
    logic [3:0]  beat_cnt4;

    assign in_data = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    vif_rr_arbiter dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .lock_en(lock_en),
        .out_data(out_data), .out_last(out_last), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready), .beat_cnt(beat_cnt)
    );

    vif_rr_arbiter #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready4), .lock_en(lock_en),
        .out_data(out_data4), .out_last(out_last4), .out_chan(out_chan4),
        .out_valid(out_valid4), .out_ready(out_ready), .beat_cnt(beat_cnt4)
    );

    int checks = 0;
    int errors = 0;

    // Model: pointer, locked channel (-1 = none), output beat, counters
    int         m_ptr, m_lock, m_oc, m_cnt, m_cnt4;
    bit         m_ov, m_ol;
    logic [7:0] m_od;

    function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", nm, a, e, $time);
        end
    endfunction

    function automatic void m_reset();
        m_ptr = 0; m_lock = -1; m_ov = 0; m_ol = 0;
        m_od = '0; m_oc = 0; m_cnt = 0; m_cnt4 = 0;
    endfunction

    function automatic int m_grant();
        if (m_ov && !out_ready) return -1;
        if (m_lock >= 0) return in_valid[m_lock] ? m_lock : -1;
        for (int j = 0; j < 4; j++) begin
            int c;
            c = (m_ptr + j) % 4;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic cycle();
        int         g;
        bit         lst;
        logic [3:0] er;
        @(negedge clk);
        g  = m_grant();
        er = (g >= 0) ? 4'(1 << g) : 4'd0;
        chk("in_ready", {28'd0, in_ready}, {28'd0, er});
        chk("in_ready4", {28'd0, in_ready4}, {28'd0, er});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        if (m_ov) begin
            chk("out_data", {24'd0, out_data}, {24'd0, m_od});
            chk("out_last", {31'd0, out_last}, {31'd0, m_ol});
            chk("out_chan", {30'd0, out_chan}, m_oc);
        end
        chk("beat_cnt", {16'd0, beat_cnt}, m_cnt);
        chk("beat_cnt4", {28'd0, beat_cnt4}, m_cnt4);
        lst = (g >= 0) ? in_last[g] : 1'b0;
        if (!m_ov || out_ready) begin
            m_ov = (g >= 0);
            if (g >= 0) begin
                m_od = d[g]; m_ol = lst; m_oc = g;
            end
        end
        if (g >= 0) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
            m_ptr = (g + 1) % 4;
            if (m_lock < 0 && lock_en && !lst) m_lock = g;
            else if (m_lock >= 0 && lst) m_lock = -1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = '0; in_last = '0; lock_en = 0; out_ready = 1;
        reset = 1;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 0;
    endtask

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       lk;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] ch;
        int         cnt;
    } vec_t;

    vec_t tbl[16];

    initial begin
        for (int i = 0; i < 4; i++) d[i] = 8'(8'h11 * (i + 1));
        reset = 1;
        in_valid = '0; in_last = '0; lock_en = 0; out_ready = 1;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 0;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_in_ready", {28'd0, in_ready}, 0);
        chk("rst_beat_cnt", {16'd0, beat_cnt}, 0);
        chk("rst_out_data", {24'd0, out_data}, 0);
        chk("rst_out_chan", {30'd0, out_chan}, 0);
        cycle();

        // Round robin over 1111, then ch1 alone, then a locked 3-beat packet on ch2
        for (int i = 0; i < 8; i++)
            tbl[i] = '{4'b1111, 4'b0000, 0, 4'(1 << (i % 4)), i != 0,
                       2'((i + 3) % 4), i};
        tbl[8]  = '{4'b0010, 4'b0000, 0, 4'b0010, 1, 2'd3, 8};
        tbl[9]  = '{4'b0111, 4'b0000, 1, 4'b0100, 1, 2'd1, 9};
        tbl[10] = '{4'b0111, 4'b0000, 1, 4'b0100, 1, 2'd2, 10};
        tbl[11] = '{4'b0111, 4'b0100, 1, 4'b0100, 1, 2'd2, 11};
        tbl[12] = '{4'b0111, 4'b0111, 1, 4'b0001, 1, 2'd2, 12};
        tbl[13] = '{4'b0011, 4'b0011, 1, 4'b0010, 1, 2'd0, 13};
        tbl[14] = '{4'b0000, 4'b0000, 0, 4'b0000, 1, 2'd1, 14};
        tbl[15] = '{4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 14};
        for (int i = 0; i < 16; i++) begin
            in_valid = tbl[i].v; in_last = tbl[i].l;
            lock_en = tbl[i].lk; out_ready = 1;
            #1;
            chk($sformatf("tbl%0d_rdy", i), {28'd0, in_ready}, {28'd0, tbl[i].rdy});
            chk($sformatf("tbl%0d_ov", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
            if (tbl[i].ov)
                chk($sformatf("tbl%0d_ch", i), {30'd0, out_chan}, {30'd0, tbl[i].ch});
            chk($sformatf("tbl%0d_cnt", i), {16'd0, beat_cnt}, tbl[i].cnt);
            cycle();
        end

        // Stall with A5 held on the output
        d[3] = 8'hA5; d[0] = 8'h3C;
        in_valid = 4'b1000; in_last = 4'b1000; lock_en = 0; out_ready = 1;
        cycle();
        in_valid = 4'b1111; in_last = 4'b1111; out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_data", {24'd0, out_data}, 32'hA5);
            chk("stall_rdy", {28'd0, in_ready}, 0);
            cycle();
        end
        out_ready = 1;
        cycle();
        in_valid = 4'b0000;
        #1;
        chk("post_stall_ch", {30'd0, out_chan}, 0);
        chk("post_stall_data", {24'd0, out_data}, 32'h3C);
        cycle();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
            in_valid  = 4'($urandom);
            in_last   = 4'($urandom) & 4'($urandom);
            lock_en   = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            cycle();
        end

        // Reset while locked on ch1
        do_reset();
        in_valid = 4'b0010; in_last = 4'b0000; lock_en = 1; out_ready = 1;
        cycle();
        in_valid = 4'b0011;
        #1;
        chk("locked_rdy", {28'd0, in_ready}, 32'b0010);
        #2 reset = 1;
        #1;
        chk("midrst_ov", {31'd0, out_valid}, 0);
        chk("midrst_cnt", {16'd0, beat_cnt}, 0);
        m_reset();
        @(posedge clk);
        #1 reset = 0;
        in_last = 4'b0011; lock_en = 0;
        #1;
        chk("rst_ptr_rdy", {28'd0, in_ready}, 32'b0001);
        cycle();

        // Counter saturation on the narrow instance
        do_reset();
        in_valid = 4'b1111; in_last = 4'b1111;
        for (int i = 0; i < 20; i++) cycle();
        in_valid = 4'b0000;
        cycle();
        chk("sat_cnt16", {16'd0, beat_cnt}, 20);
        chk("sat_cnt4", {28'd0, beat_cnt4}, 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
